// File: rtl/sort8_frame_stream.sv
// sort8_frame_stream: frames a valid/ready word stream around the 8-input sort network and replays the sorted frame.
// Define SORT8_DESCEND_EN for descending emission with all-zeros padding.
module sort8_frame_stream #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic [8*W-1:0] srt_din,
  input  logic [8*W-1:0] srt_dout,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last
);
`ifdef SORT8_DESCEND_EN
  localparam logic [W-1:0] PAD = '0;
`else
  localparam logic [W-1:0] PAD = '1;
`endif
  typedef enum logic [1:0] {FILL, SORT, DRAIN} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_slot [8];
  logic [W-1:0] r_res [8];
  logic [3:0] r_wr_cnt, r_len;
  logic [2:0] r_rd_cnt, w_idx;
  logic w_in_hs, w_close, w_out_hs, w_done;
  assign w_in_hs  = in_valid && in_ready;
  assign w_close  = w_in_hs && (in_last || r_wr_cnt == 4'd7);
  assign w_out_hs = out_valid && out_ready;
  assign w_done   = w_out_hs && out_last;
`ifdef SORT8_DESCEND_EN
  assign w_idx = ~r_rd_cnt;
`else
  assign w_idx = r_rd_cnt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FILL;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    in_ready  = r_state == FILL;
    out_valid = r_state == DRAIN;
    out_data  = out_valid ? r_res[w_idx] : '0;
    out_last  = out_valid && ({1'b0, r_rd_cnt} == r_len - 4'd1);
    w_next    = r_state == FILL ? (w_close ? SORT : FILL) :
                r_state == SORT ? DRAIN : (w_done ? FILL : DRAIN);
  end
  for (genvar k = 0; k < 8; k++) begin : g_din
    assign srt_din[k*W +: W] = r_slot[k];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_len    <= '0;
      for (int k = 0; k < 8; k++) begin
        r_slot[k] <= PAD;
        r_res[k]  <= '0;
      end
    end else begin
      if (w_in_hs) begin
        r_slot[r_wr_cnt[2:0]] <= in_data;
        r_wr_cnt <= r_wr_cnt + 4'd1;
      end
      if (w_close) r_len <= r_wr_cnt + 4'd1;
      if (r_state == SORT) begin
        for (int k = 0; k < 8; k++) r_res[k] <= srt_dout[k*W +: W];
        r_rd_cnt <= '0;
      end
      if (w_out_hs) r_rd_cnt <= r_rd_cnt + 3'd1;
      // Closing handshake re-arms the slots with padding for the next frame
      if (w_done) begin
        r_wr_cnt <= '0;
        for (int k = 0; k < 8; k++) r_slot[k] <= PAD;
      end
    end
  end
endmodule

// File: tb/tb_sort8_frame_stream.sv
// tb_sort8_frame_stream: randomized self-checking bench with a behavioural sorter and frame reference model.
module tb_sort8_frame_stream;
  localparam int W = 32;
`ifdef SORT8_DESCEND_EN
  localparam logic [W-1:0] PAD = '0;
`else
  localparam logic [W-1:0] PAD = '1;
`endif
  logic clk = 0, rst = 0;
  logic in_valid = 0, in_last = 0, out_ready = 1;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid, out_last;
  logic [W-1:0] out_data;
  logic [8*W-1:0] srt_din, srt_dout;
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0, out_cyc = 0, unstable = 0, tmo = 0;
  logic [W-1:0] fr_q[$], exp_q[$], got_q[$];
  bit last_q[$];

  sort8_frame_stream #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .srt_din(srt_din), .srt_dout(srt_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [8*W-1:0] sort_net(input logic [8*W-1:0] d);
    logic [W-1:0] a [8];
    logic [W-1:0] t;
    logic [8*W-1:0] r;
    for (int i = 0; i < 8; i++) a[i] = d[i*W +: W];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    for (int i = 0; i < 8; i++) r[i*W +: W] = a[i];
    return r;
  endfunction

  always_comb srt_dout = sort_net(srt_din);

  task automatic ref_frame();
    logic [W-1:0] t;
    exp_q = fr_q;
    for (int i = 0; i < exp_q.size(); i++)
      for (int j = 0; j + 1 < exp_q.size() - i; j++)
        if (exp_q[j] > exp_q[j+1]) begin t = exp_q[j]; exp_q[j] = exp_q[j+1]; exp_q[j+1] = t; end
`ifdef SORT8_DESCEND_EN
    exp_q.reverse();
`endif
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1; in_data = d; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL in_accept_timeout got in_ready=%0b exp 1", in_ready);
    end else begin
      @(posedge clk); @(negedge clk); acc_cyc = cyc;
    end
    in_valid = 0; in_last = 0;
  endtask

  task automatic send_frame(input logic close);
    for (int i = 0; i < fr_q.size(); i++) send_word(fr_q[i], close && i == fr_q.size() - 1);
  endtask

  task automatic collect(input int n, input int pat);
    logic [W-1:0] hd;
    logic hl;
    bit hv = 0, take;
    int k = 0;
    got_q.delete(); last_q.delete(); unstable = 0; tmo = 0;
    while (got_q.size() < n && k < 300) begin
      out_ready = pat == 0 ? 1'b1 : pat == 1 ? (k % 3 == 0) : 1'($urandom % 2);
      take = 0;
      if (out_valid) begin
        if (hv && (out_data !== hd || out_last !== hl)) unstable++;
        if (out_ready) begin got_q.push_back(out_data); last_q.push_back(out_last); hv = 0; take = 1; end
        else begin hv = 1; hd = out_data; hl = out_last; end
      end else if (hv) unstable++;
      @(posedge clk); @(negedge clk); k++;
      if (take) out_cyc = cyc;
    end
    if (got_q.size() < n) tmo = 1;
    out_ready = 1;
  endtask

  task automatic check_frame(input string nm);
    ref_frame();
    tests++;
    if (got_q.size() !== exp_q.size() || tmo !== 0) begin
      fails++; $display("FAIL %s_count got %0d exp %0d", nm, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      tests++;
      if (got_q[i] !== exp_q[i] || last_q[i] !== (i == exp_q.size() - 1)) begin
        fails++;
        $display("FAIL %s_word%0d got %h/%0b exp %h/%0b", nm, i, got_q[i], last_q[i], exp_q[i], i == exp_q.size() - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; @(negedge clk); @(negedge clk);
    tests++;
    if (in_ready !== 1 || out_valid !== 0 || out_last !== 0 || out_data !== '0) begin
      fails++; $display("FAIL reset_outputs got rdy=%0b v=%0b l=%0b d=%h exp 1 0 0 0", in_ready, out_valid, out_last, out_data);
    end
    tests++;
    if (srt_din !== {8{PAD}}) begin fails++; $display("FAIL reset_din got %h exp %h", srt_din, {8{PAD}}); end
    rst = 0; @(negedge clk);
  endtask

  task automatic test_full();
    logic [8*W-1:0] ed;
    fr_q = '{7, 3, 9, 1, 8, 2, 6, 4};
    for (int k = 0; k < 8; k++) ed[k*W +: W] = fr_q[k];
    send_frame(0);
    tests++;
    if (in_ready !== 0 || out_valid !== 0) begin
      fails++; $display("FAIL full_sort_state got rdy=%0b v=%0b exp 0 0", in_ready, out_valid);
    end
    tests++;
    if (srt_din !== ed) begin fails++; $display("FAIL full_din got %h exp %h", srt_din, ed); end
    ref_frame();
    @(negedge clk);
    tests++;
    if (out_valid !== 1 || out_data !== exp_q[0]) begin
      fails++; $display("FAIL full_latency got v=%0b d=%h exp 1 %h", out_valid, out_data, exp_q[0]);
    end
    collect(8, 0);
    check_frame("full");
    tests++;
    if (in_ready !== 1 || out_valid !== 0) begin
      fails++; $display("FAIL full_refill got rdy=%0b v=%0b exp 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_partial();
    fr_q = '{50, 10, 30};
    send_frame(1);
    tests++;
    if (srt_din[3*W +: 5*W] !== {5{PAD}} || srt_din[0 +: 3*W] !== {W'(30), W'(10), W'(50)}) begin
      fails++; $display("FAIL partial_din got %h exp pad above 3 words", srt_din);
    end
    collect(3, 0);
    check_frame("partial");
    @(negedge clk); @(negedge clk);
    tests++;
    if (out_valid !== 0) begin fails++; $display("FAIL partial_no_pad got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_backpressure();
    fr_q = '{8, 7, 6, 5, 4, 3, 2, 1};
    send_frame(0);
    collect(8, 1);
    check_frame("bp");
    tests++;
    if (unstable !== 0) begin fails++; $display("FAIL bp_stable got %0d changes exp 0", unstable); end
  endtask

  task automatic test_reset_mid();
    fr_q.delete();
    for (int i = 0; i < 8; i++) fr_q.push_back($urandom);
    send_frame(0);
    collect(3, 0);
    rst = 1; #1;
    tests++;
    if (out_valid !== 0 || in_ready !== 1) begin
      fails++; $display("FAIL rstmid_outputs got v=%0b rdy=%0b exp 0 1", out_valid, in_ready);
    end
    @(negedge clk); rst = 0;
    fr_q = '{5, 4};
    send_frame(1);
    collect(2, 0);
    check_frame("rstmid");
    @(negedge clk);
    tests++;
    if (out_valid !== 0) begin fails++; $display("FAIL rstmid_extra got v=%0b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] nxt[$];
    for (int i = 0; i < 8; i++) nxt.push_back($urandom);
    fr_q = '{32'hFFFF_FFFE};
    send_frame(1);
    fork
      collect(1, 0);
      send_word(nxt[0], 0);
    join
    check_frame("single");
    tests++;
    if (acc_cyc - out_cyc !== 1) begin fails++; $display("FAIL b2b_gap got %0d exp 1", acc_cyc - out_cyc); end
    for (int i = 1; i < 8; i++) send_word(nxt[i], 0);
    fr_q = nxt;
    collect(8, 0);
    check_frame("b2b");
  endtask

  task automatic test_random();
    int len;
    logic cl;
    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 8);
      fr_q.delete();
      for (int i = 0; i < len; i++) fr_q.push_back(f % 4 == 0 ? W'($urandom_range(0, 3)) : W'($urandom));
      cl = len < 8 ? 1'b1 : 1'($urandom % 2);
      send_frame(cl);
      collect(len, 2);
      check_frame("rand");
      tests++;
      if (unstable !== 0) begin fails++; $display("FAIL rand_stable got %0d changes exp 0", unstable); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full();
    test_partial();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
